// File: rtl/gen_palabras_sec_if.sv
// Word-pair stimulus bus: start/mode/ready in, words, valid, index and done out.
interface gen_palabras_sec_if #(
    parameter int N     = 4,
    parameter int IDX_W = 4
);
    logic             iniciar;
    logic             modo;
    logic             listo;
    logic [N-1:0]     palabraA;
    logic [N-1:0]     palabraB;
    logic             valido;
    logic [IDX_W-1:0] indice;
    logic             terminado;

    modport master (
        input  iniciar, modo, listo,
        output palabraA, palabraB, valido, indice, terminado
    );

    modport slave (
        output iniciar, modo, listo,
        input  palabraA, palabraB, valido, indice, terminado
    );
endinterface

// File: rtl/gen_palabras_sec.sv
// Clocked word-pair sequencer (directed or 16-bit LFSR) with valid/ready handshake.
// Define GEN_PALABRAS_FIRMA_EN to add the XOR signature output `firma`.
module gen_palabras_sec #(
    parameter int          N         = 4,
    parameter int          NUM_CASOS = 10,
    parameter int          ESPERA    = 0,
    parameter logic [15:0] SEMILLA   = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
`ifdef GEN_PALABRAS_FIRMA_EN
    output logic [N-1:0]       firma,
`endif
    gen_palabras_sec_if.master bus
);

    localparam int                IDX_W      = $clog2(NUM_CASOS + 1);
    localparam int                ESP_W      = (ESPERA > 0) ? $clog2(ESPERA + 1) : 1;
    localparam logic [15:0]       SEM_EF     = (SEMILLA == 16'h0) ? 16'hACE1 : SEMILLA;
    localparam logic [IDX_W-1:0]  ULTIMO     = IDX_W'(NUM_CASOS - 1);
    localparam logic [ESP_W-1:0]  CUENTA_INI = (ESPERA > 0) ? ESP_W'(ESPERA - 1) : '0;

    typedef enum logic [1:0] {REPOSO, EMITIR, PAUSA, FIN} estado_t;

    estado_t          r_estado, w_sig_estado;
    logic [N-1:0]     r_pal_a, w_sig_a;
    logic [N-1:0]     r_pal_b, w_sig_b;
    logic [IDX_W-1:0] r_indice, w_sig_indice, w_idx_inc;
    logic [15:0]      r_lfsr, w_sig_lfsr, w_lfsr_av;
    logic             r_modo, w_sig_modo;
    logic [ESP_W-1:0] r_cuenta, w_sig_cuenta;
    logic [N-1:0]     r_firma, w_sig_firma;

    function automatic logic [N-1:0] espejo(input logic [N-1:0] x);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = x[N-1-i];
        return r;
    endfunction

    function automatic logic [15:0] lfsr_avanza(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always_comb begin
        w_sig_estado = r_estado;
        w_sig_a      = r_pal_a;
        w_sig_b      = r_pal_b;
        w_sig_indice = r_indice;
        w_sig_lfsr   = r_lfsr;
        w_sig_modo   = r_modo;
        w_sig_cuenta = r_cuenta;
        w_sig_firma  = r_firma;
        w_lfsr_av    = lfsr_avanza(r_lfsr);
        w_idx_inc    = r_indice + 1'b1;

        case (r_estado)
            REPOSO, FIN: begin
                if (bus.iniciar) begin
                    w_sig_estado = EMITIR;
                    w_sig_modo   = bus.modo;
                    w_sig_indice = '0;
                    w_sig_firma  = '0;
                    // Pair 0 comes from the LFSR as it stands; it is never reseeded here.
                    if (bus.modo) begin
                        w_sig_a = r_lfsr[N-1:0];
                        w_sig_b = r_lfsr[2*N-1:N];
                    end else begin
                        w_sig_a = '0;
                        w_sig_b = '0;
                    end
                end
            end
            EMITIR: begin
                if (bus.listo) begin
                    w_sig_firma = r_firma ^ r_pal_a ^ r_pal_b;
                    if (r_modo) w_sig_lfsr = w_lfsr_av;
                    if (r_indice < ULTIMO) begin
                        w_sig_indice = w_idx_inc;
                        if (r_modo) begin
                            w_sig_a = w_lfsr_av[N-1:0];
                            w_sig_b = w_lfsr_av[2*N-1:N];
                        end else begin
                            w_sig_a = N'(w_idx_inc);
                            w_sig_b = espejo(N'(w_idx_inc));
                        end
                        if (ESPERA > 0) begin
                            w_sig_estado = PAUSA;
                            w_sig_cuenta = CUENTA_INI;
                        end
                    end else begin
                        w_sig_estado = FIN;
                    end
                end
            end
            PAUSA: begin
                if (r_cuenta == '0) w_sig_estado = EMITIR;
                else                w_sig_cuenta = r_cuenta - 1'b1;
            end
            default: w_sig_estado = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= REPOSO;
            r_pal_a  <= '0;
            r_pal_b  <= '0;
            r_indice <= '0;
            r_lfsr   <= SEM_EF;
            r_modo   <= 1'b0;
            r_cuenta <= '0;
            r_firma  <= '0;
        end else begin
            r_estado <= w_sig_estado;
            r_pal_a  <= w_sig_a;
            r_pal_b  <= w_sig_b;
            r_indice <= w_sig_indice;
            r_lfsr   <= w_sig_lfsr;
            r_modo   <= w_sig_modo;
            r_cuenta <= w_sig_cuenta;
            r_firma  <= w_sig_firma;
        end
    end

    // All outputs decode registered state only, so listo never reaches them combinationally.
    assign bus.palabraA  = r_pal_a;
    assign bus.palabraB  = r_pal_b;
    assign bus.indice    = r_indice;
    assign bus.valido    = (r_estado == EMITIR);
    assign bus.terminado = (r_estado == FIN);
`ifdef GEN_PALABRAS_FIRMA_EN
    assign firma = r_firma;
`endif

endmodule

// File: tb/tb_gen_palabras_sec.sv
// Randomized bench for gen_palabras_sec: two instances (back-to-back and with gap) checked against a pair-list model.
`timescale 1ns/1ps
module tb_gen_palabras_sec;

    localparam int NC0  = 10;
    localparam int NC1  = 5;
    localparam int ESP0 = 0;
    localparam int ESP1 = 3;
    localparam int PRESUPUESTO = 500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic ini [2];
    logic mod [2];
    logic lst [2];
    int   m_lfsr [2];

    int n_cmp = 0;
    int n_err = 0;

    gen_palabras_sec_if #(.N(4), .IDX_W(4)) bus0 ();
    gen_palabras_sec_if #(.N(4), .IDX_W(3)) bus1 ();

    assign bus0.iniciar = ini[0];
    assign bus0.modo    = mod[0];
    assign bus0.listo   = lst[0];
    assign bus1.iniciar = ini[1];
    assign bus1.modo    = mod[1];
    assign bus1.listo   = lst[1];

`ifdef GEN_PALABRAS_FIRMA_EN
    logic [3:0] firma0, firma1;
`endif

    gen_palabras_sec #(.N(4), .NUM_CASOS(NC0), .ESPERA(ESP0), .SEMILLA(16'hACE1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef GEN_PALABRAS_FIRMA_EN
        .firma (firma0),
`endif
        .bus   (bus0)
    );

    // Seed 0 must fall back to ACE1 inside the generator.
    gen_palabras_sec #(.N(4), .NUM_CASOS(NC1), .ESPERA(ESP1), .SEMILLA(16'h0000)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef GEN_PALABRAS_FIRMA_EN
        .firma (firma1),
`endif
        .bus   (bus1)
    );

    task automatic comprobar(input string tag, input int obs, input int esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observado=%0d esperado=%0d (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // 0=A 1=B 2=valido 3=indice 4=terminado 5=firma
    function automatic int rd(input int d, input int s);
        case (s)
            0: return (d == 0) ? int'(bus0.palabraA)  : int'(bus1.palabraA);
            1: return (d == 0) ? int'(bus0.palabraB)  : int'(bus1.palabraB);
            2: return (d == 0) ? int'(bus0.valido)    : int'(bus1.valido);
            3: return (d == 0) ? int'(bus0.indice)    : int'(bus1.indice);
            4: return (d == 0) ? int'(bus0.terminado) : int'(bus1.terminado);
`ifdef GEN_PALABRAS_FIRMA_EN
            5: return (d == 0) ? int'(firma0) : int'(firma1);
`endif
            default: return -1;
        endcase
    endfunction

    function automatic int rev4(input int x);
        int r = 0;
        for (int j = 0; j < 4; j++)
            if (((x >> j) & 1) == 1) r = r | (1 << (3 - j));
        return r;
    endfunction

    // Taps 15,13,12,10 -> mask B400; feedback is the parity of the tapped bits.
    function automatic int lfsr_adv(input int l);
        return ((l << 1) & 16'hFFFF) | ($countones(l & 16'hB400) & 1);
    endfunction

    // One full run on instance d; called at a falling edge, returns at a falling edge in FIN.
    task automatic correr(input int d, input bit m, input int pct);
        int  ea[$];
        int  eb[$];
        int  nc, esp, k, gap, ciclos, fm, ret;
        bit  exp_v;
        nc  = (d == 0) ? NC0 : NC1;
        esp = (d == 0) ? ESP0 : ESP1;
        for (int i = 0; i < nc; i++) begin
            if (!m) begin
                ea.push_back(i % 16);
                eb.push_back(rev4(i % 16));
            end else begin
                ea.push_back(m_lfsr[d] & 15);
                eb.push_back((m_lfsr[d] >> 4) & 15);
                m_lfsr[d] = lfsr_adv(m_lfsr[d]);
            end
        end
        k = 0; gap = 0; ciclos = 0; fm = 0; ret = 0;
        ini[d] = 1'b1;
        mod[d] = m;
        lst[d] = 1'b0;
        @(negedge clk);
        ini[d] = 1'b0;
        while (k < nc && ciclos < PRESUPUESTO) begin
            exp_v = (gap == 0);
            comprobar("valido",       rd(d, 2), int'(exp_v));
            comprobar("terminado_run", rd(d, 4), 0);
            comprobar("indice",       rd(d, 3), k);
            comprobar("palabraA",     rd(d, 0), ea[k]);
            comprobar("palabraB",     rd(d, 1), eb[k]);
`ifdef GEN_PALABRAS_FIRMA_EN
            comprobar("firma_run",    rd(d, 5), fm);
`endif
            if (pct < 0) begin
                lst[d] = !(k == 2 && ret < 5);
                if (k == 2 && ret < 5) ret++;
            end else begin
                lst[d] = ($urandom_range(99) < pct);
            end
            // Stray start pulses and mode flips during a run must be ignored.
            ini[d] = ($urandom_range(7) == 0);
            mod[d] = $urandom_range(1);
            if (exp_v && lst[d]) begin
                fm = fm ^ ea[k] ^ eb[k];
                k++;
                gap = (k < nc) ? esp : 0;
            end else if (!exp_v) begin
                gap--;
            end
            @(negedge clk);
            ciclos++;
        end
        ini[d] = 1'b0;
        lst[d] = 1'b0;
        if (ciclos >= PRESUPUESTO) comprobar("timeout", 1, 0);
        comprobar("terminado",  rd(d, 4), 1);
        comprobar("valido_fin", rd(d, 2), 0);
        comprobar("A_fin",      rd(d, 0), ea[nc-1]);
        comprobar("B_fin",      rd(d, 1), eb[nc-1]);
        comprobar("indice_fin", rd(d, 3), nc - 1);
`ifdef GEN_PALABRAS_FIRMA_EN
        comprobar("firma_fin",  rd(d, 5), fm);
`endif
        repeat (2) @(negedge clk);
        comprobar("terminado_hold", rd(d, 4), 1);
        comprobar("A_hold",         rd(d, 0), ea[nc-1]);
    endtask

    task automatic chequeo_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            comprobar({tag, "_valido"},    rd(d, 2), 0);
            comprobar({tag, "_A"},         rd(d, 0), 0);
            comprobar({tag, "_B"},         rd(d, 1), 0);
            comprobar({tag, "_indice"},    rd(d, 3), 0);
            comprobar({tag, "_terminado"}, rd(d, 4), 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ini[d] = 1'b0;
            mod[d] = 1'b0;
            lst[d] = 1'b0;
            m_lfsr[d] = 16'hACE1;
        end
        repeat (2) @(negedge clk);
        chequeo_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        correr(0, 1'b0, 100);
        correr(0, 1'b0, -1);
        correr(0, 1'b1, 100);
        correr(0, 1'b1, 60);
        correr(1, 1'b1, 70);
        correr(1, 1'b0, 50);

        // Asynchronous reset in the middle of a run at indice 2.
        ini[0] = 1'b1; mod[0] = 1'b0; lst[0] = 1'b1;
        @(negedge clk);
        ini[0] = 1'b0;
        repeat (2) @(negedge clk);
        comprobar("pre_rst_indice", rd(0, 3), 2);
        comprobar("pre_rst_valido", rd(0, 2), 1);
        #2 rst_n = 1'b0;
        #1;
        chequeo_reset("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'hACE1;
        repeat (3) @(negedge clk);
        comprobar("sin_reinicio_valido", rd(0, 2), 0);
        comprobar("sin_reinicio_term",   rd(0, 4), 0);
        lst[0] = 1'b0;

        correr(0, 1'b1, 80);
        for (int r = 0; r < 4; r++)
            correr(int'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(100, 30)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
